// File: rtl/spi_responder.sv
// spi_responder: SPI target (CPHA=0, mode 0 or 2 via CPOL) oversampled on the board clock.
// Shifts bytes MSB first. Received bytes land in a one-entry holding register with valid/ack;
// transmit bytes come from a 4-entry FIFO, or IDLE_BYTE when the FIFO is empty at byte start.
//
// Ports:
//   i_clk      board clock, all state on posedge
//   i_rst      asynchronous active-high reset
//   i_sck      SPI clock from master (asynchronous)
//   i_mosi     SPI data from master (asynchronous)
//   i_nss      active-low chip select (asynchronous)
//   o_miso     SPI data to master (1 while idle)
//   o_miso_oe  tri-state enable for MISO, high while selected
//   o_sel      synchronized select
//   o_rxd      last received byte
//   o_rxv      o_rxd valid, held until i_rxack
//   i_rxack    consume o_rxd
//   o_ovr      sticky overrun flag
//   i_clrovr   clear o_ovr
//   i_txd      byte to enqueue
//   i_txwr     enqueue i_txd when not full
//   o_txcnt    FIFO occupancy 0..4
//   o_txfull   FIFO full
module spi_responder #(
   parameter bit         CPOL      = 1'b0,
   parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sck,
   input  logic       i_mosi,
   input  logic       i_nss,
   output logic       o_miso,
   output logic       o_miso_oe,
   output logic       o_sel,
   output logic [7:0] o_rxd,
   output logic       o_rxv,
   input  logic       i_rxack,
   output logic       o_ovr,
   input  logic       i_clrovr,
   input  logic [7:0] i_txd,
   input  logic       i_txwr,
   output logic [2:0] o_txcnt,
   output logic       o_txfull
);

   typedef enum logic {StIdle, StActive} state_t;

   // Synchronizers (raw pin levels) and edge-detect flop (internal polarity)
   logic r_sck_m, r_sck_s, r_sck_q;
   logic r_mosi_m, r_mosi_s;
   logic r_nss_m, r_nss_s;

   state_t     r_state, w_state_d;
   logic [2:0] r_bitcnt, w_bitcnt_d;
   logic [7:0] r_rxsr, w_rxsr_d;
   logic [7:0] r_txsr, w_txsr_d;
   logic       r_reload, w_reload_d;
   logic [7:0] r_rxd, w_rxd_d;
   logic       r_rxv, w_rxv_d;
   logic       r_ovr, w_ovr_d;

   logic [7:0] r_fifo [4];
   logic [1:0] r_wptr, r_rptr;
   logic [2:0] r_cnt, w_cnt_d;

   logic       w_sck_s, w_rise, w_fall;
   logic       w_push, w_pop;
   logic [7:0] w_tx_next;

   assign w_sck_s   = r_sck_s ^ CPOL;
   assign w_rise    = w_sck_s & ~r_sck_q;
   assign w_fall    = ~w_sck_s & r_sck_q;
   assign w_push    = i_txwr & (r_cnt != 3'd4);
   assign w_tx_next = (r_cnt != 3'd0) ? r_fifo[r_rptr] : IDLE_BYTE;
   assign w_cnt_d   = r_cnt + {2'b00, w_push} - {2'b00, w_pop};

   always_comb begin
      w_state_d  = r_state;
      w_bitcnt_d = r_bitcnt;
      w_rxsr_d   = r_rxsr;
      w_txsr_d   = r_txsr;
      w_reload_d = r_reload;
      w_rxd_d    = r_rxd;
      w_rxv_d    = r_rxv;
      w_ovr_d    = r_ovr;
      w_pop      = 1'b0;
      if (i_rxack)  w_rxv_d = 1'b0;
      // An overrun below overrides this clear
      if (i_clrovr) w_ovr_d = 1'b0;
      case (r_state)
         StIdle: begin
            if (!r_nss_s) begin
               w_state_d  = StActive;
               w_bitcnt_d = 3'd0;
               w_reload_d = 1'b0;
               w_txsr_d   = w_tx_next;
               w_pop      = (r_cnt != 3'd0);
            end
         end
         StActive: begin
            if (r_nss_s) begin
               // Abort: partial byte discarded silently
               w_state_d  = StIdle;
               w_bitcnt_d = 3'd0;
               w_reload_d = 1'b0;
            end else if (w_rise) begin
               w_rxsr_d   = {r_rxsr[6:0], r_mosi_s};
               w_bitcnt_d = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) begin
                  w_reload_d = 1'b1;
                  if (!r_rxv || i_rxack) begin
                     w_rxd_d = {r_rxsr[6:0], r_mosi_s};
                     w_rxv_d = 1'b1;
                  end else begin
                     w_ovr_d = 1'b1;
                  end
               end
            end else if (w_fall) begin
               if (r_reload) begin
                  w_txsr_d   = w_tx_next;
                  w_pop      = (r_cnt != 3'd0);
                  w_reload_d = 1'b0;
               end else begin
                  w_txsr_d = {r_txsr[6:0], 1'b1};
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sck_m  <= CPOL;
         r_sck_s  <= CPOL;
         r_sck_q  <= 1'b0;
         r_mosi_m <= 1'b1;
         r_mosi_s <= 1'b1;
         r_nss_m  <= 1'b1;
         r_nss_s  <= 1'b1;
         r_state  <= StIdle;
         r_bitcnt <= 3'd0;
         r_rxsr   <= 8'h00;
         r_txsr   <= 8'h00;
         r_reload <= 1'b0;
         r_rxd    <= 8'h00;
         r_rxv    <= 1'b0;
         r_ovr    <= 1'b0;
         r_wptr   <= 2'd0;
         r_rptr   <= 2'd0;
         r_cnt    <= 3'd0;
      end else begin
         r_sck_m  <= i_sck;
         r_sck_s  <= r_sck_m;
         r_sck_q  <= w_sck_s;
         r_mosi_m <= i_mosi;
         r_mosi_s <= r_mosi_m;
         r_nss_m  <= i_nss;
         r_nss_s  <= r_nss_m;
         r_state  <= w_state_d;
         r_bitcnt <= w_bitcnt_d;
         r_rxsr   <= w_rxsr_d;
         r_txsr   <= w_txsr_d;
         r_reload <= w_reload_d;
         r_rxd    <= w_rxd_d;
         r_rxv    <= w_rxv_d;
         r_ovr    <= w_ovr_d;
         if (w_push) r_wptr <= r_wptr + 2'd1;
         if (w_pop)  r_rptr <= r_rptr + 2'd1;
         r_cnt    <= w_cnt_d;
      end
   end

   // FIFO storage needs no reset; occupancy gates every read
   always_ff @(posedge i_clk) begin
      if (w_push) r_fifo[r_wptr] <= i_txd;
   end

   assign o_miso    = (r_state == StActive) ? r_txsr[7] : 1'b1;
   assign o_miso_oe = (r_state == StActive);
   assign o_sel     = (r_state == StActive);
   assign o_rxd     = r_rxd;
   assign o_rxv     = r_rxv;
   assign o_ovr     = r_ovr;
   assign o_txcnt   = r_cnt;
   assign o_txfull  = (r_cnt == 3'd4);

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed bench for spi_responder. A CPOL=0 and a CPOL=1 instance share all
// stimulus; the CPOL=1 instance sees the inverted SCK so it must behave identically.
module tb_spi_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b0;
   logic       mosi = 1'b1;
   logic       nss = 1'b1;
   logic       rxack = 1'b0;
   logic       clrovr = 1'b0;
   logic [7:0] txd = 8'h00;
   logic       txwr = 1'b0;

   logic       miso0, oe0, sel0, rxv0, ovr0, txfull0;
   logic [7:0] rxd0;
   logic [2:0] txcnt0;
   logic       miso1, oe1, sel1, rxv1, ovr1, txfull1;
   logic [7:0] rxd1;
   logic [2:0] txcnt1;
   logic       sck1;

   int checks = 0;
   int errors = 0;

   assign sck1 = ~sck;

   always #5 clk = ~clk;

   spi_responder #(.CPOL(1'b0), .IDLE_BYTE(8'hFF)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_mosi(mosi), .i_nss(nss),
      .o_miso(miso0), .o_miso_oe(oe0), .o_sel(sel0), .o_rxd(rxd0), .o_rxv(rxv0),
      .i_rxack(rxack), .o_ovr(ovr0), .i_clrovr(clrovr), .i_txd(txd), .i_txwr(txwr),
      .o_txcnt(txcnt0), .o_txfull(txfull0)
   );

   spi_responder #(.CPOL(1'b1), .IDLE_BYTE(8'hFF)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_sck(sck1), .i_mosi(mosi), .i_nss(nss),
      .o_miso(miso1), .o_miso_oe(oe1), .o_sel(sel1), .o_rxd(rxd1), .o_rxv(rxv1),
      .i_rxack(rxack), .o_ovr(ovr1), .i_clrovr(clrovr), .i_txd(txd), .i_txwr(txwr),
      .o_txcnt(txcnt1), .o_txfull(txfull1)
   );

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      txd  = d;
      txwr = 1'b1;
      clks(1);
      txwr = 1'b0;
   endtask

   task automatic select_dev();
      nss = 1'b0;
      clks(6);
   endtask

   task automatic deselect_dev();
      nss = 1'b1;
      clks(6);
   endtask

   task automatic pulse_ack();
      rxack = 1'b1;
      clks(1);
      rxack = 1'b0;
   endtask

   // Master side, CPHA=0: MOSI set while SCK low, MISO sampled at the leading edge.
   // ack_last raises RXACK exactly in the cycle the final rise is acted on.
   task automatic xfer(input logic [7:0] tx, input int nbits, input bit ack_last,
                       output logic [7:0] r0, output logic [7:0] r1);
      r0 = 8'h00;
      r1 = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         clks(4);
         r0 = {r0[6:0], miso0};
         r1 = {r1[6:0], miso1};
         sck = 1'b1;
         if (ack_last && (i == nbits - 1)) begin
            clks(2);
            rxack = 1'b1;
            clks(1);
            rxack = 1'b0;
            clks(1);
         end else begin
            clks(4);
         end
         sck = 1'b0;
         clks(4);
      end
      mosi = 1'b1;
   endtask

   initial begin
      logic [7:0] r0, r1;
      logic [7:0] exp_b;

      // Reset values
      clks(3);
      check("rst_miso", miso0, 1'b1);
      check("rst_oe", oe0, 1'b0);
      check("rst_sel", sel0, 1'b0);
      check("rst_rxd", rxd0, 8'h00);
      check("rst_rxv", rxv0, 1'b0);
      check("rst_txcnt", txcnt0, 3'd0);
      rst = 1'b0;
      clks(3);

      // Loopback
      push(8'hA5);
      check("lb_txcnt_pre", txcnt0, 3'd1);
      select_dev();
      check("lb_sel", sel0, 1'b1);
      check("lb_oe", oe0, 1'b1);
      xfer(8'h3C, 8, 1'b0, r0, r1);
      check("lb_miso0", r0, 8'hA5);
      check("lb_miso1", r1, 8'hA5);
      check("lb_rxd0", rxd0, 8'h3C);
      check("lb_rxd1", rxd1, 8'h3C);
      check("lb_rxv0", rxv0, 1'b1);
      check("lb_rxv1", rxv1, 1'b1);
      check("lb_txcnt0", txcnt0, 3'd0);
      check("lb_txcnt1", txcnt1, 3'd0);
      deselect_dev();
      check("idle_miso", miso0, 1'b1);
      check("idle_oe", oe0, 1'b0);
      check("idle_sel", sel0, 1'b0);
      pulse_ack();
      check("ack_rxv", rxv0, 1'b0);

      // Empty FIFO, then full FIFO burst
      select_dev();
      for (int i = 0; i < 2; i++) begin
         xfer(8'h00, 8, 1'b0, r0, r1);
         check("empty_miso", r0, 8'hFF);
         pulse_ack();
      end
      deselect_dev();
      for (int i = 1; i <= 4; i++) push(8'(i));
      check("full_txcnt", txcnt0, 3'd4);
      check("full_flag", txfull0, 1'b1);
      push(8'h05);
      check("full_ignore", txcnt0, 3'd4);
      select_dev();
      for (int i = 0; i < 5; i++) begin
         exp_b = (i < 4) ? 8'(i + 1) : 8'hFF;
         xfer(8'h10, 8, 1'b0, r0, r1);
         check("burst_miso", r0, exp_b);
         pulse_ack();
      end
      deselect_dev();
      check("burst_txcnt", txcnt0, 3'd0);
      check("burst_full", txfull0, 1'b0);

      // Overrun
      select_dev();
      xfer(8'h11, 8, 1'b0, r0, r1);
      xfer(8'h22, 8, 1'b0, r0, r1);
      check("ovr_rxd", rxd0, 8'h11);
      check("ovr_flag", ovr0, 1'b1);
      check("ovr_rxv", rxv0, 1'b1);
      clrovr = 1'b1;
      clks(1);
      clrovr = 1'b0;
      check("ovr_clr", ovr0, 1'b0);
      xfer(8'h33, 8, 1'b1, r0, r1);
      check("ackc_rxd", rxd0, 8'h33);
      check("ackc_rxv", rxv0, 1'b1);
      check("ackc_ovr", ovr0, 1'b0);
      pulse_ack();
      deselect_dev();

      // Abort after 5 bits
      push(8'h77);
      push(8'h88);
      check("ab_txcnt2", txcnt0, 3'd2);
      select_dev();
      check("ab_txcnt1", txcnt0, 3'd1);
      xfer(8'hF0, 5, 1'b0, r0, r1);
      check("ab_partial", r0, 8'h0E);
      deselect_dev();
      check("ab_rxv", rxv0, 1'b0);
      check("ab_ovr", ovr0, 1'b0);
      check("ab_txcnt_kept", txcnt0, 3'd1);
      select_dev();
      check("ab_txcnt0", txcnt0, 3'd0);
      xfer(8'h0F, 8, 1'b0, r0, r1);
      check("ab_next_miso", r0, 8'h88);
      check("ab_next_rxd", rxd0, 8'h0F);
      deselect_dev();

      // Reset mid-transfer (RXV still set from the byte above)
      push(8'h99);
      push(8'hAA);
      select_dev();
      xfer(8'hC3, 3, 1'b0, r0, r1);
      rst = 1'b1;
      #1;
      check("mr_miso", miso0, 1'b1);
      check("mr_oe", oe0, 1'b0);
      check("mr_sel", sel0, 1'b0);
      check("mr_rxd", rxd0, 8'h00);
      check("mr_rxv", rxv0, 1'b0);
      check("mr_ovr", ovr0, 1'b0);
      check("mr_txcnt", txcnt0, 3'd0);
      check("mr_txfull", txfull0, 1'b0);
      clks(2);
      rst = 1'b0;
      clks(6);
      check("mr_resel", sel0, 1'b1);
      xfer(8'h5A, 8, 1'b0, r0, r1);
      check("mr_miso_byte", r0, 8'hFF);
      check("mr_rxd_byte", rxd0, 8'h5A);
      check("mr_rxv_byte", rxv0, 1'b1);
      deselect_dev();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI target (slave) for the extension board's bit-banged SPI port: the far end of the SCK/MOSI/nSS/MISO lines driven by the Gigatron ctrl-code logic. It oversamples the SPI pins on the board clock and shifts bytes in and out, MSB first. Received bytes go to a one-entry holding register with valid/ack. Transmit bytes come from a 4-entry FIFO, or an idle byte when the FIFO is empty. It serves as a synthesizable stand-in device for bench and bring-up, and as the SPI front end of an on-board peripheral.

## Interface
- CPOL, default 0: SCK idle level; internal clock is SCK ^ CPOL, so mode 0 or mode 2 (CPHA=0 always).
- IDLE_BYTE, default 8'hFF: byte shifted out when the TX FIFO is empty at byte start.
- CLK  in  1  board clock; all state on posedge.
- RST  in  1  reset, asynchronous, active-high.
- SCK  in  1  SPI clock from master, asynchronous.
- MOSI  in  1  SPI data from master, asynchronous.
- nSS  in  1  chip select, active-low, asynchronous.
- MISO  out  1  SPI data to master.
- MISO_OE  out  1  tri-state enable for MISO; 1 while selected.
- SEL  out  1  synchronized select (= !nSS_s).
- RXD  out  8  last received byte.
- RXV  out  1  RXD valid; held until RXACK.
- RXACK  in  1  consume RXD; clears RXV.
- OVR  out  1  sticky overrun flag.
- CLROVR  in  1  clears OVR.
- TXD  in  8  byte to enqueue.
- TXWR  in  1  enqueue TXD when !TXFULL.
- TXCNT  out  3  FIFO occupancy, 0..4.
- TXFULL  out  1  TXCNT==4.

## Operation
- Reset values: MISO=1, MISO_OE=0, SEL=0, RXD=8'h00, RXV=0, OVR=0, TXCNT=0, TXFULL=0. FIFO pointers, BITCNT and shift registers are 0. All synchronizer flops reset to the idle pin levels (nSS=1, SCK=CPOL, MOSI=1).
- Synchronizers: SCK, MOSI and nSS each pass through 2 flops. sck_q is the previous synchronized SCK^CPOL.
  - rise = sck_s & !sck_q.
  - fall = !sck_s & sck_q.
- States: IDLE (nSS_s=1) and ACTIVE (nSS_s=0).
- IDLE→ACTIVE, on the first cycle nSS_s=0:
  - BITCNT←0.
  - TXSR←FIFO head (pop) if TXCNT>0, else IDLE_BYTE.
  - MISO_OE←1, SEL←1.
- ACTIVE, on rise:
  - RXSR←{RXSR[6:0],MOSI_s}; BITCNT←BITCNT+1 (3 bits, wraps).
  - If BITCNT was 7, the byte is complete:
    - If RXV=0 or RXACK=1: RXD←{RXSR[6:0],MOSI_s} and RXV←1.
    - Otherwise: byte dropped, OVR←1.
    - In both cases set reload.
- ACTIVE, on fall:
  - If reload: TXSR←pop or IDLE_BYTE (same rule as byte start), clear reload.
  - Otherwise: TXSR←{TXSR[6:0],1'b1}.
- MISO = TXSR[7] while ACTIVE, 1 while IDLE.
- ACTIVE→IDLE, nSS_s=1 at any point:
  - Partial byte is discarded; no RXV, no OVR.
  - BITCNT←0, reload←0, MISO_OE←0, SEL←0.
  - A byte already popped for the aborted transfer is lost; the rest of the FIFO is untouched.
- Rise and fall are mutually exclusive by construction. SCK edges while IDLE are ignored.
- RXACK with RXV=0 has no effect. RXACK in the same cycle as a byte completion loads the new byte, RXV stays 1, no overrun.
- CLROVR and an overrun in the same cycle: OVR ends at 1 (set wins).
- TXWR while TXFULL is ignored. TXWR and pop in the same cycle: both happen, TXCNT unchanged. TXWR and pop with TXCNT=0: IDLE_BYTE is sent and TXD is enqueued, TXCNT←1.
- FIFO pointers are 2 bits and wrap modulo 4.

## Timing
- Pin-to-detect latency: 3 CLK (2 sync + edge flop).
- Master constraints:
  - SCK high and low phases ≥4 CLK each.
  - nSS low to first SCK edge ≥4 CLK.
  - Last SCK edge to nSS high ≥4 CLK.
  - MOSI stable ≥3 CLK before and after each rising SCK.
- MISO valid 1 CLK after the fall detect, or 1 CLK after the select detect. That is ≤4 CLK after the pin edge, always before the next rising SCK under the constraints above.
- RXV asserts 1 CLK after the 8th rise detect.
- TXCNT/TXFULL update the cycle after TXWR or pop.

## Test plan
- Reset mid-transfer: assert RST after 3 bits → all outputs at reset values immediately. With nSS still low after release, a fresh byte starts from bit 0.
- Loopback, mode 0: enqueue 8'hA5, master sends 8'h3C → master reads 8'hA5, RXD=8'h3C, RXV=1, TXCNT=0.
- Empty FIFO and burst: select with TXCNT=0, clock 2 bytes → MISO bytes 8'hFF, 8'hFF. Then enqueue 8'h01..8'h04 (TXFULL=1), 5th TXWR of 8'h05 is ignored, 5-byte transfer returns 01,02,03,04,FF.
- Overrun: send 8'h11 then 8'h22 without RXACK → RXD=8'h11, OVR=1. CLROVR → OVR=0. RXACK on the completion cycle of 8'h33 → RXD=8'h33, RXV=1, OVR=0.
- Abort: nSS high after 5 bits of 8'hF0 with 8'h77 popped → RXV stays 0, 8'h77 is lost, and the next transfer sends the next FIFO entry.
- CPOL=1 instance: SCK idles high, same loopback as the mode 0 test → identical data results.
